// File: rtl/csr_neighbor_fetcher.sv
// csr_neighbor_fetcher: expands one CSR vertex into its neighbour list over graph_memory reads.
// Statistics counters are built only when CSR_FETCH_STATS_EN is defined.
//
//  state    | meaning
//  IDLE     | ready to accept a vertex ID
//  IDX0     | strobe rowidx[v]
//  IDX1     | strobe rowidx[v+1]
//  WAIT_IDX | collect start/end bounds
//  FETCH    | issue edge reads on ports A/B, gated by FIFO credit
//  DRAIN    | wait for reads and FIFO to empty, then pulse done
module csr_neighbor_fetcher #(
    parameter int PROC_BITS  = 4,
    parameter int PROC_ID    = 0,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [31:0]           vtx_in,
    input  logic                  vtx_valid_in,
    output logic                  vtx_ready_out,
    output logic [31+PROC_BITS:0] idx_addr_out,
    output logic                  idx_valid_out,
    input  logic [31:0]           rowidx_in,
    input  logic                  rowidx_valid_in,
    output logic [31+PROC_BITS:0] data_addra_out,
    output logic                  data_valida_out,
    output logic [31+PROC_BITS:0] data_addrb_out,
    output logic                  data_validb_out,
    input  logic [31:0]           data_ina,
    input  logic                  data_valida_in,
    input  logic [31:0]           data_inb,
    input  logic                  data_validb_in,
    output logic [31:0]           nbr_out,
    output logic                  nbr_valid_out,
    output logic                  nbr_last_out,
    input  logic                  nbr_ready_in,
    output logic                  done_out,
    output logic                  err_out,
    output logic [31:0]           edge_cnt_out,
    output logic [31:0]           fetch_cyc_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;
    localparam int IW = $clog2(MEM_LAT + 3);
    localparam logic [PROC_BITS-1:0] TAG     = PROC_BITS'(PROC_ID);
    localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_IDX0, S_IDX1, S_WAIT_IDX, S_FETCH, S_DRAIN
    } state_t;

    state_t        state, state_d;
    logic [31:0]   vtx_q, start_q, end_q, next_q, next_d, rcv_q;
    logic          idx_seen_q, err_q;
    logic [IW-1:0] idx_out_q;
    logic [CW-1:0] out_a_q, out_b_q, count_q, need;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [32:0]   mem [FIFO_DEPTH];

    logic          accept, idx_take, a_wr, b_wr, stray, range_err, rd, a_last, b_last;
    logic [31:0]   len, remain;
    logic [1:0]    wr_n;

    assign accept   = vtx_valid_in && (state == S_IDLE);
    assign idx_take = rowidx_valid_in && (idx_out_q != '0);
    assign a_wr     = data_valida_in && (out_a_q != '0);
    assign b_wr     = data_validb_in && (out_b_q != '0);
    // Responses with nothing outstanding on their port are leftovers (e.g. from before a reset).
    assign stray    = (rowidx_valid_in && !idx_take) || (data_valida_in && !a_wr) ||
                      (data_validb_in && !b_wr);
    assign len      = end_q - start_q;
    assign remain   = end_q - next_q;
    assign a_last   = (rcv_q == len - 32'd1);
    assign b_last   = ((rcv_q + {31'd0, a_wr}) == len - 32'd1);
    assign wr_n     = {1'b0, a_wr} + {1'b0, b_wr};
    assign rd       = (count_q != '0) && nbr_ready_in;

    always_comb begin
        state_d         = state;
        next_d          = next_q;
        need            = '0;
        idx_valid_out   = 1'b0;
        idx_addr_out    = '0;
        data_valida_out = 1'b0;
        data_addra_out  = '0;
        data_validb_out = 1'b0;
        data_addrb_out  = '0;
        done_out        = 1'b0;
        range_err       = 1'b0;
        case (state)
            S_IDLE: if (accept) state_d = S_IDX0;
            S_IDX0: begin
                idx_valid_out = 1'b1;
                idx_addr_out  = {TAG, vtx_q};
                state_d       = S_IDX1;
            end
            S_IDX1: begin
                idx_valid_out = 1'b1;
                idx_addr_out  = {TAG, vtx_q + 32'd1};
                state_d       = S_WAIT_IDX;
            end
            S_WAIT_IDX: if (idx_take && idx_seen_q) begin
                if (rowidx_in > start_q) begin
                    state_d = S_FETCH;
                end else begin
                    range_err = (rowidx_in < start_q);
                    state_d   = S_DRAIN;
                end
            end
            S_FETCH: begin
                // Credit covers every read in flight so the FIFO can never overflow.
                need = (remain > 32'd1) ? CW'(2) : CW'(1);
                if (DEPTH_C - count_q >= out_a_q + out_b_q + need) begin
                    data_valida_out = 1'b1;
                    data_addra_out  = {TAG, next_q};
                    if (remain > 32'd1) begin
                        data_validb_out = 1'b1;
                        data_addrb_out  = {TAG, next_q + 32'd1};
                    end
                    next_d = next_q + 32'(need);
                    if (remain == 32'(need)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (idx_out_q == '0 && out_a_q == '0 && out_b_q == '0 && count_q == '0) begin
                done_out = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= S_IDLE;
            vtx_q      <= '0;
            start_q    <= '0;
            end_q      <= '0;
            next_q     <= '0;
            rcv_q      <= '0;
            idx_seen_q <= 1'b0;
            idx_out_q  <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state     <= state_d;
            idx_out_q <= idx_out_q + IW'(idx_valid_out) - IW'(idx_take);
            if (accept) begin
                vtx_q      <= vtx_in;
                idx_seen_q <= 1'b0;
                rcv_q      <= '0;
            end else begin
                rcv_q <= rcv_q + 32'(wr_n);
            end
            if (idx_take) begin
                if (!idx_seen_q) begin
                    start_q    <= rowidx_in;
                    idx_seen_q <= 1'b1;
                end else begin
                    end_q <= rowidx_in;
                end
            end
            next_q  <= (state == S_WAIT_IDX) ? start_q : next_d;
            out_a_q <= out_a_q + CW'(data_valida_out) - CW'(a_wr);
            out_b_q <= out_b_q + CW'(data_validb_out) - CW'(b_wr);
            wptr_q  <= wptr_q + AW'(wr_n);
            rptr_q  <= rptr_q + AW'(rd);
            count_q <= count_q + CW'(wr_n) - CW'(rd);
            if (stray || range_err) err_q <= 1'b1;
        end
    end

    // Same-cycle A and B responses land in address order: A first, B behind it.
    always_ff @(posedge clk_in) begin
        if (a_wr) mem[wptr_q] <= {a_last, data_ina};
        if (b_wr) mem[a_wr ? wptr_q + AW'(1) : wptr_q] <= {b_last, data_inb};
    end

    assign vtx_ready_out = (state == S_IDLE);
    assign nbr_valid_out = (count_q != '0);
    assign nbr_out       = nbr_valid_out ? mem[rptr_q][31:0] : '0;
    assign nbr_last_out  = nbr_valid_out && mem[rptr_q][32];
    assign err_out       = err_q;

`ifdef CSR_FETCH_STATS_EN
    logic [31:0] edge_cnt_q, fetch_cyc_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            edge_cnt_q  <= '0;
            fetch_cyc_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_q + 32'(wr_n);
            if (state != S_IDLE) fetch_cyc_q <= fetch_cyc_q + 32'd1;
        end
    end

    assign edge_cnt_out  = edge_cnt_q;
    assign fetch_cyc_out = fetch_cyc_q;
`else
    assign edge_cnt_out  = '0;
    assign fetch_cyc_out = '0;
`endif

endmodule

// File: tb/tb_csr_neighbor_fetcher.sv
// Scoreboard bench for csr_neighbor_fetcher with a fixed-latency graph_memory model.
module tb_csr_neighbor_fetcher;
    localparam int PB  = 4;
    localparam int PID = 3;
    localparam int PW  = 32 + PB;
`ifdef CSR_FETCH_STATS_EN
    localparam int EXP_EDGES = 3;
    localparam int EXP_CYC   = 11;
`else
    localparam int EXP_EDGES = 0;
    localparam int EXP_CYC   = 0;
`endif

    typedef struct packed { logic last; logic [31:0] nbr; } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic [31:0]   vtx_in = '0;
    logic          vtx_valid_in = 1'b0;
    logic          vtx_ready_out;
    logic [PW-1:0] idx_addr_out, data_addra_out, data_addrb_out;
    logic          idx_valid_out, data_valida_out, data_validb_out;
    logic [31:0]   rowidx_in, data_ina, data_inb;
    logic          rowidx_valid_in, data_valida_in, data_validb_in;
    logic [31:0]   nbr_out;
    logic          nbr_valid_out, nbr_last_out;
    logic          nbr_ready_in = 1'b1;
    logic          done_out, err_out;
    logic [31:0]   edge_cnt_out, fetch_cyc_out;

    int checks = 0, errors = 0, cyc = 0;
    int a_strb = 0, b_strb = 0, done_cnt = 0;
    int t_acc = 0, t_done = 0, first_idx = -1, first_data = -1, first_nbr = -1;
    exp_t sb[$];
    exp_t e;
    logic [31:0] rowidx_mem [16];
    logic [31:0] data_mem [64];

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    csr_neighbor_fetcher #(.PROC_BITS(PB), .PROC_ID(PID), .MEM_LAT(2), .FIFO_DEPTH(8)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .vtx_in(vtx_in), .vtx_valid_in(vtx_valid_in), .vtx_ready_out(vtx_ready_out),
        .idx_addr_out(idx_addr_out), .idx_valid_out(idx_valid_out),
        .rowidx_in(rowidx_in), .rowidx_valid_in(rowidx_valid_in),
        .data_addra_out(data_addra_out), .data_valida_out(data_valida_out),
        .data_addrb_out(data_addrb_out), .data_validb_out(data_validb_out),
        .data_ina(data_ina), .data_valida_in(data_valida_in),
        .data_inb(data_inb), .data_validb_in(data_validb_in),
        .nbr_out(nbr_out), .nbr_valid_out(nbr_valid_out), .nbr_last_out(nbr_last_out),
        .nbr_ready_in(nbr_ready_in), .done_out(done_out), .err_out(err_out),
        .edge_cnt_out(edge_cnt_out), .fetch_cyc_out(fetch_cyc_out)
    );

    // graph_memory: two-cycle in-order response per port, unaffected by the DUT reset
    logic        iv1 = 1'b0, iv2 = 1'b0, av1 = 1'b0, av2 = 1'b0, bv1 = 1'b0, bv2 = 1'b0;
    logic [31:0] ia1 = '0, ia2 = '0, aa1 = '0, aa2 = '0, ba1 = '0, ba2 = '0;
    always @(posedge clk_in) begin
        iv1 <= idx_valid_out;   iv2 <= iv1; ia1 <= idx_addr_out[31:0];   ia2 <= ia1;
        av1 <= data_valida_out; av2 <= av1; aa1 <= data_addra_out[31:0]; aa2 <= aa1;
        bv1 <= data_validb_out; bv2 <= bv1; ba1 <= data_addrb_out[31:0]; ba2 <= ba1;
    end
    assign rowidx_valid_in = iv2;
    assign rowidx_in       = rowidx_mem[ia2[3:0]];
    assign data_valida_in  = av2;
    assign data_ina        = data_mem[aa2[5:0]];
    assign data_validb_in  = bv2;
    assign data_inb        = data_mem[ba2[5:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic last, input logic [31:0] v);
        sb.push_back(exp_t'{last, v});
    endtask

    // monitor: pops the scoreboard on every delivered neighbour, tracks strobes and timing
    always @(negedge clk_in) begin
        if (vtx_valid_in && vtx_ready_out) begin
            t_acc = cyc; first_idx = -1; first_data = -1; first_nbr = -1;
        end
        if (idx_valid_out) begin
            chk("idx_tag", idx_addr_out[PW-1:32], PID);
            if (first_idx < 0) first_idx = cyc;
        end
        if (data_valida_out) begin
            a_strb++;
            chk("a_tag", data_addra_out[PW-1:32], PID);
            if (first_data < 0) first_data = cyc;
        end
        if (data_validb_out) begin
            b_strb++;
            chk("b_tag", data_addrb_out[PW-1:32], PID);
        end
        if (nbr_valid_out && first_nbr < 0) first_nbr = cyc;
        if (done_out) begin done_cnt++; t_done = cyc; end
        if (nbr_valid_out && nbr_ready_in) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL nbr_unexpected actual=%0d required=none", nbr_out);
            end else begin
                e = sb.pop_front();
                chk("nbr_data", nbr_out, e.nbr);
                chk("nbr_last", nbr_last_out, e.last);
            end
        end
    end

    task automatic send_vtx(input logic [31:0] v);
        @(posedge clk_in); #1;
        vtx_in = v; vtx_valid_in = 1'b1;
        @(posedge clk_in); #1;
        vtx_valid_in = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0, n;
        d0 = done_cnt; n = 0;
        while (done_cnt == d0 && n < budget) begin @(posedge clk_in); n++; end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        repeat (2) @(posedge clk_in); #1;
        chk({name, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int a0, b0, a1, n;
        for (int i = 0; i < 64; i++) data_mem[i] = 32'(100 + i);
        data_mem[10] = 7; data_mem[11] = 9; data_mem[12] = 4;
        for (int i = 0; i < 16; i++) rowidx_mem[i] = '0;
        rowidx_mem[0] = 0;  rowidx_mem[1] = 20; rowidx_mem[2] = 40;
        rowidx_mem[3] = 20; rowidx_mem[4] = 20; rowidx_mem[5] = 10;
        rowidx_mem[6] = 13; rowidx_mem[7] = 9;  rowidx_mem[8] = 4;

        repeat (2) @(posedge clk_in); #1;
        chk("rst_vtx_ready", vtx_ready_out, 1);
        chk("rst_nbr_valid", nbr_valid_out, 0);
        chk("rst_idx_valid", idx_valid_out, 0);
        chk("rst_data_valid", {data_valida_out, data_validb_out}, 0);
        chk("rst_done", done_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_stats", {edge_cnt_out, fetch_cyc_out}, 0);
        @(negedge clk_in); rst_n_in = 1'b1;

        // basic expansion 5 -> 7,9,4
        push(0, 7); push(0, 9); push(1, 4);
        send_vtx(5);
        wait_done("basic", 60);
        chk("basic_err", err_out, 0);
        chk("basic_sb_empty", sb.size(), 0);
        chk("lat_idx", first_idx - t_acc, 1);
        chk("lat_data", first_data - t_acc, 5);
        chk("lat_nbr", first_nbr - t_acc, 8);
        chk("stat_edges", edge_cnt_out, EXP_EDGES);
        chk("stat_cycles", fetch_cyc_out, EXP_CYC);

        // empty range
        send_vtx(3);
        wait_done("empty", 60);
        chk("empty_no_data", first_data, -1);
        chk("empty_no_nbr", first_nbr, -1);
        chk("empty_done_lat", t_done - t_acc, 5);
        chk("empty_err", err_out, 0);

        // backpressure: 20 neighbours, consumer stalled
        @(posedge clk_in); #1 nbr_ready_in = 1'b0;
        for (int i = 0; i < 20; i++) push(i == 19, data_mem[i]);
        a0 = a_strb; b0 = b_strb;
        send_vtx(0);
        repeat (40) @(posedge clk_in); #1;
        chk("bp_a_strobes", a_strb - a0, 4);
        chk("bp_b_strobes", b_strb - b0, 4);
        chk("bp_nbr_valid", nbr_valid_out, 1);
        nbr_ready_in = 1'b1;
        wait_done("bp", 300);
        chk("bp_sb_empty", sb.size(), 0);
        chk("bp_a_total", a_strb - a0, 10);
        chk("bp_b_total", b_strb - b0, 10);
        chk("bp_err", err_out, 0);

        // end < start
        a0 = a_strb; b0 = b_strb;
        send_vtx(7);
        wait_done("neg", 60);
        chk("neg_err", err_out, 1);
        chk("neg_no_strobes", (a_strb - a0) + (b_strb - b0), 0);
        chk("neg_vtx_ready", vtx_ready_out, 1);
        chk("neg_done_lat", t_done - t_acc, 5);

        // reset during FETCH with reads in flight
        @(negedge clk_in); rst_n_in = 1'b0;
        @(negedge clk_in); rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        chk("rst2_err_clear", err_out, 0);
        nbr_ready_in = 1'b0;
        a0 = a_strb;
        send_vtx(1);
        n = 0;
        while (a_strb - a0 < 2 && n < 100) begin @(posedge clk_in); n++; end
        if (a_strb - a0 < 2) begin
            checks++; errors++;
            $display("FAIL midrst_timeout actual=%0d required=2", a_strb - a0);
        end
        @(negedge clk_in); #2 rst_n_in = 1'b0;
        #1;
        chk("midrst_nbr_valid", nbr_valid_out, 0);
        chk("midrst_nbr", nbr_out, 0);
        chk("midrst_strobes", {idx_valid_out, data_valida_out, data_validb_out}, 0);
        chk("midrst_done", done_out, 0);
        chk("midrst_err", err_out, 0);
        chk("midrst_vtx_ready", vtx_ready_out, 1);
        #1 rst_n_in = 1'b1;
        a1 = a_strb;
        sb.delete();
        nbr_ready_in = 1'b1;
        repeat (6) @(posedge clk_in); #1;
        chk("stray_err", err_out, 1);
        chk("stray_nbr_valid", nbr_valid_out, 0);
        chk("stray_no_strobes", a_strb - a1, 0);
        chk("stray_vtx_ready", vtx_ready_out, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
